monkey_state_ctrl: RTL and testbench

Frame-based state controller that sequences the monkey movement/collision datapath. It sits between the keypad/collision logic and the movement block. It converts raw key and collision inputs into gated walk commands and a single-cycle jump request, and a freeze control. It also owns the hit/respawn/lives sequence, including a reset-style respawn pulse that returns the movement block to its start position.

---
 rtl/monkey_pkg.sv | 27 ++
 rtl/monkey_state_ctrl_if.sv | 38 +++
 rtl/frame_down_counter.sv | 26 ++
 rtl/monkey_state_ctrl.sv | 171 +++++++++++++++++
 tb/tb_monkey_state_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/monkey_pkg.sv
// Shared types and constants for the monkey state controller slice:
// state encoding, collision edge-bit positions and keypad digit codes.
package monkey_pkg;

    typedef enum logic [2:0] {
        ST_GROUND   = 3'd0,
        ST_AIR      = 3'd1,
        ST_CLIMB    = 3'd2,
        ST_HIT      = 3'd3,
        ST_RESPAWN  = 3'd4,
        ST_GAMEOVER = 3'd5
    } monkey_state_e;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    localparam logic [3:0] DIGIT_LEFT  = 4'd4;
    localparam logic [3:0] DIGIT_RIGHT = 4'd6;

    // States in which the player controls the monkey.
    function automatic logic is_active(input monkey_state_e s);
        return (s == ST_GROUND) || (s == ST_AIR) || (s == ST_CLIMB);
    endfunction

endpackage

// File: rtl/monkey_state_ctrl_if.sv
// Signal bundle between keypad/collision logic, the state controller and
// the movement block. master drives the raw inputs, slave is the controller.
interface monkey_state_ctrl_if;

    logic       startOfFrame;
    logic       jumpIsPressed;
    logic       digitIsPressed;
    logic [3:0] digit;
    logic       wallCollision;
    logic       ladderCollision;
    logic       enemyCollision;
    logic [3:0] HitEdgeCode;

    logic       walkLeft;
    logic       walkRight;
    logic       jumpPulse;
    logic       motionFreeze;
    logic       respawnPulse;
    logic       invulnerable;
    logic [1:0] lives;
    logic       gameOver;
    logic [2:0] monkeyState;

    modport master (
        output startOfFrame, jumpIsPressed, digitIsPressed, digit,
               wallCollision, ladderCollision, enemyCollision, HitEdgeCode,
        input  walkLeft, walkRight, jumpPulse, motionFreeze, respawnPulse,
               invulnerable, lives, gameOver, monkeyState
    );

    modport slave (
        input  startOfFrame, jumpIsPressed, digitIsPressed, digit,
               wallCollision, ladderCollision, enemyCollision, HitEdgeCode,
        output walkLeft, walkRight, jumpPulse, motionFreeze, respawnPulse,
               invulnerable, lives, gameOver, monkeyState
    );

endinterface

// File: rtl/frame_down_counter.sv
// 8-bit frame counter: load wins over decrement, decrements once per
// startOfFrame and holds at zero. Only the zero flag is consumed.
module frame_down_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       sof,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (sof && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/monkey_state_ctrl.sv
// Frame-based monkey state controller: gates walk/jump commands, owns the
// hit / respawn / lives sequence and drives freeze and respawn controls.
module monkey_state_ctrl
    import monkey_pkg::*;
#(
    parameter int HIT_FREEZE_FRAMES    = 30,
    parameter int INVULN_FRAMES        = 60,
    parameter int JUMP_COOLDOWN_FRAMES = 4,
    parameter int MAX_AIR_FRAMES       = 90,
    parameter int INITIAL_LIVES        = 3
) (
    input logic              clk,
    input logic              reset,
    monkey_state_ctrl_if.slave bus
);

    monkey_state_e state, state_nxt;
    logic [1:0]    lives_r, lives_nxt, lives_dec;
    logic [7:0]    air_cnt, air_cnt_nxt;
    logic          jump_d, ground_seen, ladder_seen;
    logic          sof, landed, jump_edge, enemy_hit, air_timeout;
    logic          ground_eff, ladder_eff;
    logic          freeze_zero, inv_zero, cool_zero;
    logic          load_freeze, load_inv, load_cool, jump_fire;
    logic          edge_top_unused;

    assign sof             = bus.startOfFrame;
    assign edge_top_unused = bus.HitEdgeCode[EDGE_TOP];
    // Standing on a floor: bottom contact without a side contact.
    assign landed      = bus.wallCollision & bus.HitEdgeCode[EDGE_BOTTOM] &
                         ~(bus.HitEdgeCode[EDGE_LEFT] | bus.HitEdgeCode[EDGE_RIGHT]);
    assign jump_edge   = bus.jumpIsPressed & ~jump_d;
    assign enemy_hit   = bus.enemyCollision & inv_zero;
    assign air_timeout = sof && (air_cnt == 8'(MAX_AIR_FRAMES - 1));
    assign ground_eff  = ground_seen | landed;
    assign ladder_eff  = ladder_seen | bus.ladderCollision;
    assign lives_dec   = (lives_r == 2'd0) ? 2'd0 : lives_r - 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_AIR;
            lives_r     <= 2'(INITIAL_LIVES);
            air_cnt     <= 8'd0;
            jump_d      <= 1'b0;
            ground_seen <= 1'b0;
            ladder_seen <= 1'b0;
        end else begin
            state       <= state_nxt;
            lives_r     <= lives_nxt;
            air_cnt     <= air_cnt_nxt;
            jump_d      <= bus.jumpIsPressed;
            ground_seen <= sof ? 1'b0 : ground_eff;
            ladder_seen <= sof ? 1'b0 : ladder_eff;
        end
    end

    always_comb begin
        state_nxt   = state;
        lives_nxt   = lives_r;
        load_freeze = 1'b0;
        load_inv    = 1'b0;
        load_cool   = 1'b0;
        jump_fire   = 1'b0;
        case (state)
            ST_GROUND, ST_AIR, ST_CLIMB: begin
                if (enemy_hit) begin
                    state_nxt   = ST_HIT;
                    lives_nxt   = lives_dec;
                    load_freeze = 1'b1;
                end else if (bus.ladderCollision) begin
                    state_nxt = ST_CLIMB;
                end else if (state == ST_GROUND) begin
                    if (jump_edge && cool_zero) begin
                        state_nxt = ST_AIR;
                        jump_fire = 1'b1;
                    end else if (sof && !ground_eff) begin
                        state_nxt = ST_AIR;
                    end
                end else if (state == ST_AIR) begin
                    if (landed) begin
                        state_nxt = ST_GROUND;
                        load_cool = 1'b1;
                    end else if (air_timeout) begin
                        // A fall that lasts too long costs a life like an enemy hit.
                        state_nxt   = ST_HIT;
                        lives_nxt   = lives_dec;
                        load_freeze = 1'b1;
                    end
                end else begin
                    if (jump_edge) begin
                        state_nxt = ST_AIR;
                        jump_fire = 1'b1;
                    end else if (sof && !ladder_eff) begin
                        state_nxt = ST_AIR;
                    end
                end
            end
            ST_HIT: begin
                if (sof && freeze_zero) begin
                    state_nxt = (lives_r == 2'd0) ? ST_GAMEOVER : ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                state_nxt = ST_AIR;
                load_inv  = 1'b1;
            end
            ST_GAMEOVER: state_nxt = ST_GAMEOVER;
            default:     state_nxt = ST_AIR;
        endcase
    end

    // Air frames count only while staying airborne; any other path clears it.
    always_comb begin
        air_cnt_nxt = 8'd0;
        if ((state == ST_AIR) && (state_nxt == ST_AIR)) begin
            air_cnt_nxt = (sof && (air_cnt != 8'hFF)) ? air_cnt + 8'd1 : air_cnt;
        end
    end

    frame_down_counter u_freeze_cnt (
        .clk      (clk),
        .reset    (reset),
        .sof      (sof),
        .load     (load_freeze),
        .load_val (8'(HIT_FREEZE_FRAMES)),
        .zero     (freeze_zero)
    );

    frame_down_counter u_inv_cnt (
        .clk      (clk),
        .reset    (reset),
        .sof      (sof),
        .load     (load_inv),
        .load_val (8'(INVULN_FRAMES)),
        .zero     (inv_zero)
    );

    frame_down_counter u_cool_cnt (
        .clk      (clk),
        .reset    (reset),
        .sof      (sof),
        .load     (load_cool),
        .load_val (8'(JUMP_COOLDOWN_FRAMES)),
        .zero     (cool_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.walkLeft     <= 1'b0;
            bus.walkRight    <= 1'b0;
            bus.jumpPulse    <= 1'b0;
            bus.motionFreeze <= 1'b0;
            bus.respawnPulse <= 1'b0;
            bus.gameOver     <= 1'b0;
        end else begin
            bus.walkLeft     <= is_active(state_nxt) & bus.digitIsPressed &
                                (bus.digit == DIGIT_LEFT);
            bus.walkRight    <= is_active(state_nxt) & bus.digitIsPressed &
                                (bus.digit == DIGIT_RIGHT);
            bus.jumpPulse    <= jump_fire;
            bus.motionFreeze <= (state_nxt == ST_HIT) || (state_nxt == ST_GAMEOVER);
            bus.respawnPulse <= (state_nxt == ST_RESPAWN);
            bus.gameOver     <= (state_nxt == ST_GAMEOVER);
        end
    end

    assign bus.invulnerable = ~inv_zero;
    assign bus.lives        = lives_r;
    assign bus.monkeyState  = state;

endmodule

// File: tb/tb_monkey_state_ctrl.sv
// Scenario bench for monkey_state_ctrl: each task drives one behaviour and
// compares the packed output vector against expectations queued beforehand.
module tb_monkey_state_ctrl;

    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_WL   = 7'b1000000;
    localparam logic [6:0] F_WR   = 7'b0100000;
    localparam logic [6:0] F_JP   = 7'b0010000;
    localparam logic [6:0] F_MF   = 7'b0001000;
    localparam logic [6:0] F_RP   = 7'b0000100;
    localparam logic [6:0] F_INV  = 7'b0000010;
    localparam logic [6:0] F_GO   = 7'b0000001;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got, expv;

    monkey_state_ctrl_if bus ();

    monkey_state_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers (stimulus only) ----------------
    function automatic logic [11:0] mk(input logic [2:0] st, input logic [1:0] lv,
                                       input logic [6:0] fl);
        return {st, lv, fl};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.monkeyState, bus.lives, bus.walkLeft, bus.walkRight, bus.jumpPulse,
                bus.motionFreeze, bus.respawnPulse, bus.invulnerable, bus.gameOver};
    endfunction

    task automatic set_floor(input logic on);
        bus.wallCollision = on;
        bus.HitEdgeCode   = on ? 4'b0001 : 4'b0000;
    endtask

    task automatic cyc(input logic sof_i);
        bus.startOfFrame = sof_i;
        @(posedge clk);
        #1;
        bus.startOfFrame = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            cyc(1'b0);
            cyc(1'b0);
            cyc(1'b0);
        end
    endtask

    task automatic apply_reset(input logic floor_after);
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        set_floor(floor_after);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        bus.startOfFrame   = 1'b0;
        bus.jumpIsPressed  = 1'b0;
        bus.digitIsPressed = 1'b0;
        bus.digit          = 4'd0;
        bus.ladderCollision = 1'b0;
        bus.enemyCollision = 1'b0;
        set_floor(1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(3'd1, 2'd3, F_NONE));
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL reset_values got=%h exp=%h", got, expv); end
        reset = 1'b0;
        set_floor(1'b1);
        exp_q.push_back(mk(3'd0, 2'd3, F_NONE));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL reset_land got=%h exp=%h", got, expv); end
    endtask

    task automatic test_walk;
        logic [3:0] digits [3];
        logic [6:0] flags  [3];
        digits = '{4'd4, 4'd6, 4'd5};
        flags  = '{F_WL, F_WR, F_NONE};
        bus.digitIsPressed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.digit = digits[i];
            exp_q.push_back(mk(3'd0, 2'd3, flags[i]));
            cyc(1'b0);
            got = obs(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin bad++; $display("FAIL walk_%0d got=%h exp=%h", i, got, expv); end
        end
        bus.digitIsPressed = 1'b0;
        bus.digit = 4'd0;
    endtask

    task automatic test_jump;
        int pulses = 0;
        run_frames(5);
        set_floor(1'b0);
        bus.jumpIsPressed = 1'b1;
        exp_q.push_back(mk(3'd1, 2'd3, F_JP));
        for (int i = 1; i < 10; i++) exp_q.push_back(mk(3'd1, 2'd3, F_NONE));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0);
            pulses += int'(bus.jumpPulse);
            got = obs(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin bad++; $display("FAIL jump_hold_%0d got=%h exp=%h", i, got, expv); end
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL jump_pulse_count got=%0d exp=1", pulses); end
        bus.jumpIsPressed = 1'b0;
        set_floor(1'b1);
        exp_q.push_back(mk(3'd0, 2'd3, F_NONE));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL jump_land got=%h exp=%h", got, expv); end
        bus.jumpIsPressed = 1'b1;
        exp_q.push_back(mk(3'd0, 2'd3, F_NONE));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL jump_cooldown_0 got=%h exp=%h", got, expv); end
        bus.jumpIsPressed = 1'b0;
        cyc(1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1);
            bus.jumpIsPressed = 1'b1;
            exp_q.push_back((k == 4) ? mk(3'd1, 2'd3, F_JP) : mk(3'd0, 2'd3, F_NONE));
            cyc(1'b0);
            got = obs(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin bad++; $display("FAIL jump_cooldown_%0d got=%h exp=%h", k, got, expv); end
            bus.jumpIsPressed = 1'b0;
            exp_q.push_back(mk(3'd0, 2'd3, F_NONE));
            cyc(1'b0);
            got = obs(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin bad++; $display("FAIL jump_release_%0d got=%h exp=%h", k, got, expv); end
        end
    endtask

    task automatic test_hit;
        bus.enemyCollision = 1'b1;
        exp_q.push_back(mk(3'd3, 2'd2, F_MF));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL hit_enter got=%h exp=%h", got, expv); end
        bus.enemyCollision = 1'b0;
        for (int f = 1; f <= 30; f++) begin
            exp_q.push_back(mk(3'd3, 2'd2, F_MF));
            cyc(1'b1);
            got = obs(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin bad++; $display("FAIL hit_freeze_%0d got=%h exp=%h", f, got, expv); end
            cyc(1'b0);
            cyc(1'b0);
            cyc(1'b0);
        end
        exp_q.push_back(mk(3'd4, 2'd2, F_RP));
        exp_q.push_back(mk(3'd1, 2'd2, F_INV));
        exp_q.push_back(mk(3'd0, 2'd2, F_INV));
        for (int i = 0; i < 3; i++) begin
            cyc(i == 0);
            got = obs(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin bad++; $display("FAIL respawn_seq_%0d got=%h exp=%h", i, got, expv); end
        end
        bus.enemyCollision = 1'b1;
        exp_q.push_back(mk(3'd0, 2'd2, F_INV));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL hit_while_inv got=%h exp=%h", got, expv); end
        bus.enemyCollision = 1'b0;
        run_frames(59);
        exp_q.push_back(mk(3'd0, 2'd2, F_INV));
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL inv_frame59 got=%h exp=%h", got, expv); end
        exp_q.push_back(mk(3'd0, 2'd2, F_NONE));
        cyc(1'b1);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL inv_frame60 got=%h exp=%h", got, expv); end
    endtask

    task automatic test_gameover;
        bus.enemyCollision = 1'b1;
        exp_q.push_back(mk(3'd3, 2'd1, F_MF));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL hit2_enter got=%h exp=%h", got, expv); end
        bus.enemyCollision = 1'b0;
        run_frames(31);
        cyc(1'b0);
        run_frames(60);
        bus.enemyCollision = 1'b1;
        exp_q.push_back(mk(3'd3, 2'd0, F_MF));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL hit3_enter got=%h exp=%h", got, expv); end
        bus.enemyCollision = 1'b0;
        run_frames(30);
        exp_q.push_back(mk(3'd5, 2'd0, F_MF | F_GO));
        cyc(1'b1);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL gameover_enter got=%h exp=%h", got, expv); end
        bus.digitIsPressed = 1'b1;
        bus.digit = 4'd4;
        exp_q.push_back(mk(3'd5, 2'd0, F_MF | F_GO));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL gameover_walk got=%h exp=%h", got, expv); end
        run_frames(3);
        bus.enemyCollision = 1'b1;
        exp_q.push_back(mk(3'd5, 2'd0, F_MF | F_GO | F_NONE));
        cyc(1'b1);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL gameover_sticky got=%h exp=%h", got, expv); end
        bus.enemyCollision = 1'b0;
        bus.digitIsPressed = 1'b0;
        bus.digit = 4'd0;
    endtask

    task automatic test_ladder;
        logic       ladder_seq [6];
        logic       sof_seq    [6];
        logic [2:0] st_seq     [6];
        apply_reset(1'b0);
        ladder_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        sof_seq    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        st_seq     = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};
        for (int i = 0; i < 6; i++) begin
            bus.ladderCollision = ladder_seq[i];
            exp_q.push_back(mk(st_seq[i], 2'd3, F_NONE));
            cyc(sof_seq[i]);
            got = obs(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin bad++; $display("FAIL ladder_%0d got=%h exp=%h", i, got, expv); end
        end
        bus.ladderCollision = 1'b0;
    endtask

    task automatic test_same_cycle;
        set_floor(1'b1);
        bus.enemyCollision = 1'b1;
        exp_q.push_back(mk(3'd3, 2'd2, F_MF));
        cyc(1'b0);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL land_and_enemy got=%h exp=%h", got, expv); end
        bus.enemyCollision = 1'b0;
        run_frames(3);
        reset = 1'b1;
        #1;
        exp_q.push_back(mk(3'd1, 2'd3, F_NONE));
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL reset_mid_hit got=%h exp=%h", got, expv); end
        @(posedge clk);
        #1;
        set_floor(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(3'd1, 2'd3, F_NONE));
            cyc(1'b0);
            got = obs(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin bad++; $display("FAIL post_reset_%0d got=%h exp=%h", i, got, expv); end
        end
    endtask

    task automatic test_fall;
        run_frames(89);
        exp_q.push_back(mk(3'd1, 2'd3, F_NONE));
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL fall_frame89 got=%h exp=%h", got, expv); end
        exp_q.push_back(mk(3'd3, 2'd2, F_MF));
        cyc(1'b1);
        got = obs(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin bad++; $display("FAIL fall_frame90 got=%h exp=%h", got, expv); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_walk();
        test_jump();
        test_hit();
        test_gameover();
        test_ladder();
        test_same_cycle();
        test_fall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
